// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle out, one response back.
// Latency: bus cycle is visible 1 cycle after accept; the response is valid 1 cycle after ack/err/timeout is sampled.
// Backpressure: cmd_ready_o is low from accept until the response handshake; rsp_valid_o holds until rsp_ready_i.
module wb_cmd_initiator #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int GRANULE        = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  // A zero timeout leaves the counter idle; keep it at least one bit wide so it still elaborates.
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Ready depends on state only, so the command side never sees a combinational path from the bus.
  assign cmd_ready_o = (state == IDLE);

  // Control FSM with all bus and response outputs registered; reset drops cyc/stb without a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      sel_o         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            // Write data is driven on reads too; the responder ignores it.
            adr_o <= cmd_adr_i;
            dat_o <= cmd_dat_i;
            sel_o <= cmd_sel_i;
            we_o  <= cmd_we_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            cnt   <= '0;
            state <= BUS;
          end
        end
        BUS: begin
          if (err_i) begin
            // err has priority over a simultaneous ack: a failed cycle returns no data.
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_dat_o     <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else if (ack_i) begin
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_dat_o     <= we_o ? '0 : dat_i;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            // Counter starts at 0 on the first bus cycle, so cyc_o stays high exactly TIMEOUT_CYCLES cycles.
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_dat_o     <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            cnt           <= '0;
            state         <= RESP;
          end else if (TO_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: vector table of single transactions plus reset/ignore sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// The responder is modelled inline: ack/err raised on a chosen bus cycle, or never for the timeout case.
module tb_wb_cmd_initiator;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic [SW-1:0] sel;
  logic          we;
  logic          stb;
  logic          cyc;
  logic          ack = 1'b0;
  logic          err = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel), .we_o(we),
    .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err)
  );

  typedef struct {
    bit          we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rd;       // responder read data
    int          lat;      // bus cycles before the responder answers (0 = first cycle)
    bit          ack;
    bit          err;
    int          hold;     // cycles rsp_ready is held low after the response appears
    int          exp_cyc;  // cycles cyc_o must be high
    logic [31:0] exp_dat;
    bit          exp_err;
    bit          exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int bus_bad;
    n = 0;
    bus_bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    cmd_sel   = v.sel;
    dat_i     = v.rd;
    chk($sformatf("v%0d cmd_ready_idle", idx), {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dat   = 32'h0BAD_0BAD;  // bus must hold the registered copy, not follow the input
    while (cyc && n < 40) begin
      n++;
      if (stb !== 1'b1 || we !== v.we || adr !== v.adr || dat_o !== v.dat || sel !== v.sel)
        bus_bad++;
      ack = v.ack && (n == v.lat + 1);
      err = v.err && (n == v.lat + 1);
      @(negedge clk);
    end
    ack = 1'b0;
    err = 1'b0;
    chk($sformatf("v%0d cyc_cycles", idx), n, v.exp_cyc);
    chk($sformatf("v%0d bus_fields_bad_cycles", idx), bus_bad, 0);
    chk($sformatf("v%0d stb_after", idx), {31'b0, stb}, 32'd0);
    chk($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d rsp_dat", idx), rsp_dat, v.exp_dat);
    chk($sformatf("v%0d rsp_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d rsp_timeout", idx), {31'b0, rsp_timeout}, {31'b0, v.exp_to});
    for (int i = 0; i < v.hold; i++) begin
      cmd_valid = 1'b1;  // must not be accepted while the response is pending
      @(negedge clk);
      chk($sformatf("v%0d hold%0d rsp_valid", idx, i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d hold%0d rsp_dat", idx, i), rsp_dat, v.exp_dat);
      chk($sformatf("v%0d hold%0d cmd_ready", idx, i), {31'b0, cmd_ready}, 32'd0);
      chk($sformatf("v%0d hold%0d cyc", idx, i), {31'b0, cyc}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid_after_hs", idx), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d cmd_ready_after_hs", idx), {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    //          we  adr   dat           sel   rd            lat ack err hold cyc exp_dat       err to
    vecs[0] = '{0, 3'd1, 32'h0,        4'hF, 32'h00000001, 1,  1,  0,  0,   2,  32'h00000001, 0,  0};
    vecs[1] = '{1, 3'd2, 32'hDEADBEEF, 4'hF, 32'h12345678, 0,  1,  0,  0,   1,  32'h0,        0,  0};
    vecs[2] = '{0, 3'd7, 32'h11111111, 4'hF, 32'hAAAAAAAA, 0,  0,  0,  0,   16, 32'h0,        1,  1};
    vecs[3] = '{0, 3'd5, 32'h0,        4'hF, 32'h00000055, 2,  1,  1,  0,   3,  32'h0,        1,  0};
    vecs[4] = '{0, 3'd4, 32'h0,        4'h3, 32'hCAFEF00D, 1,  1,  0,  5,   2,  32'hCAFEF00D, 0,  0};
    vecs[5] = '{1, 3'd6, 32'h80000000, 4'h8, 32'h0,        0,  0,  1,  0,   1,  32'h0,        1,  0};
    vecs[6] = '{0, 3'd0, 32'h0,        4'h1, 32'h80000001, 3,  1,  0,  0,   4,  32'h80000001, 0,  0};

    // Reset values while reset is held.
    #12;
    chk("rst cyc", {31'b0, cyc}, 32'd0);
    chk("rst stb", {31'b0, stb}, 32'd0);
    chk("rst we", {31'b0, we}, 32'd0);
    chk("rst adr", {29'b0, adr}, 32'd0);
    chk("rst dat_o", dat_o, 32'd0);
    chk("rst sel", {28'b0, sel}, 32'd0);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rsp_dat", rsp_dat, 32'd0);
    chk("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // ack/err outside a bus cycle must be ignored.
    @(negedge clk);
    ack = 1'b1;
    err = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    err = 1'b0;
    chk("idle_ack rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle_ack cyc", {31'b0, cyc}, 32'd0);
    chk("idle_ack cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset in the second cycle of a stalled read.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_rst cyc_before", {31'b0, cyc}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst cyc_async", {31'b0, cyc}, 32'd0);
    chk("mid_rst stb_async", {31'b0, stb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    chk("post_rst rsp_valid_later", {31'b0, rsp_valid}, 32'd0);
    chk("post_rst cyc_later", {31'b0, cyc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
Single-outstanding Wishbone classic initiator. It converts a valid/ready command stream (address, data, write enable, byte select) into one Wishbone bus cycle and waits for ack or err, with a timeout counter. It returns read data and status on a valid/ready response channel. It sits between a local controller (CPU-side sequencer or test FSM) and the word-addressed register responders on the bus.

Parameters:
ADDR_WIDTH, 3, word address width on command and bus.
DATA_WIDTH, 32, data width.
GRANULE, 8, bits per byte-select lane; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam).
TIMEOUT_CYCLES, 16, maximum cycles in BUS state before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_ni  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  command present.
cmd_ready_o  out  1  command accepted when valid && ready.
cmd_we_i  in  1  1 = write, 0 = read.
cmd_adr_i  in  ADDR_WIDTH  word address.
cmd_dat_i  in  DATA_WIDTH  write data.
cmd_sel_i  in  SEL_WIDTH  byte lanes.
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  response consumed when valid && ready.
rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes and failed cycles.
rsp_err_o  out  1  cycle ended by err_i or timeout.
rsp_timeout_o  out  1  cycle ended by timeout.
adr_o  out  ADDR_WIDTH  bus address.
dat_o  out  DATA_WIDTH  bus write data.
dat_i  in  DATA_WIDTH  bus read data.
sel_o  out  SEL_WIDTH  bus byte select.
we_o  out  1  bus write enable.
stb_o  out  1  bus strobe.
cyc_o  out  1  bus cycle.
ack_i  in  1  responder acknowledge.
err_i  in  1  responder error.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; adr_o, dat_o, sel_o, rsp_dat_o = 0; timeout counter = 0. Reset during BUS drops cyc_o/stb_o immediately, with no clock edge needed. The pending command is discarded and no response is issued.
- cmd_ready_o = (state == IDLE), combinational from state only.
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on a cmd handshake. At that edge, register adr/dat/sel/we onto the bus outputs and set cyc_o = stb_o = 1. The bus cycle is visible the cycle after acceptance. dat_o is driven with the command data for reads too; it is don't-care on the bus.
- BUS: bus outputs are held stable and the counter increments each cycle.
  - ack_i or err_i sampled high at a rising edge: cyc_o = stb_o = 0 at that edge, state -> RESP.
  - On ack_i with a read: rsp_dat_o <= dat_i.
  - On ack_i with a write: rsp_dat_o <= 0.
  - ack_i and err_i high together: err wins; rsp_err_o = 1, rsp_dat_o = 0.
  - Timeout (TIMEOUT_CYCLES != 0): if the counter reaches TIMEOUT_CYCLES-1 with no ack/err, the next edge aborts. cyc_o = stb_o = 0, rsp_err_o = rsp_timeout_o = 1, rsp_dat_o = 0, state -> RESP. cyc_o is therefore high for exactly TIMEOUT_CYCLES cycles. The counter clears on leaving BUS.
- RESP: rsp_valid_o = 1. rsp_dat_o, rsp_err_o and rsp_timeout_o are held until rsp_ready_i. On the handshake edge: rsp_valid_o = 0, state -> IDLE. A new command can be accepted the cycle after.
- ack_i/err_i outside BUS are ignored and do not change outputs.
- Minimum command-to-command period with a 1-cycle-latency responder and rsp_ready_i tied high is 4 cycles:
  - accept
  - cyc
  - ack sampled
  - resp
- Counter width: clog2(TIMEOUT_CYCLES+1); with TIMEOUT_CYCLES = 0 the counter is unused and BUS waits indefinitely.

Test Plan:
- Read, responder acks one cycle after stb: cmd adr=3'b001 we=0 -> cyc_o/stb_o high 2 cycles, rsp_valid_o with rsp_dat_o=32'h00000001, rsp_err_o=0.
- Write, responder acks immediately: cmd adr=3'b010 dat=32'hDEADBEEF sel=4'hF we=1 -> bus shows those values with we_o=1 for 1 cycle, rsp_dat_o=0, rsp_err_o=0.
- Timeout: TIMEOUT_CYCLES=16, responder silent -> cyc_o high exactly 16 cycles, then rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0.
- ack_i and err_i high in the same cycle on a read -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
- Backpressure: rsp_ready_i low 5 cycles after response -> rsp_valid_o and data stable for all 5 cycles, cmd_ready_o=0 throughout, and a second cmd_valid_i is not accepted until after the handshake.
- Reset asserted mid-BUS (cycle 2 of a stalled read) -> cyc_o/stb_o low asynchronously, no rsp_valid_o after release, cmd_ready_o=1 on the first edge after reset release.
